// File: rtl/wb_retire.sv
// In-order write-back/retire queue: buffers DEPTH entries, fills loads from in-order dmem
// responses and retires one filled head entry per cycle. Retire trace ports exist with WB_TRACE_EN.
module wb_retire #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OFS_W = $clog2(XLEN / 8)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vld,
    output logic                         o_rdy,
    input  logic                         i_mem_reg,
    input  logic [XLEN-1:0]              i_res,
    input  logic [2:0]                   i_funct3,
    input  logic [4:0]                   i_rd_waddr,
    input  logic                         i_rd_wen,
    input  logic                         i_dmem_rvld,
    input  logic [XLEN-1:0]              i_dmem_rdata,
    output logic [XLEN-1:0]              o_res,
    output logic [4:0]                   o_rd_waddr,
    output logic                         o_rd_wen,
    output logic                         o_vld,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
`ifdef WB_TRACE_EN
    input  logic [31:0]                  i_inst,
    input  logic [31:0]                  i_pc,
    input  logic [31:0]                  i_nxt_pc,
    output logic [31:0]                  o_inst,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_nxt_pc,
`endif
    output logic                         o_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Per-entry flags (reset) and payload (no reset; guarded by the flags).
    logic [DEPTH-1:0] ld_q, filled_q, wen_q;
    logic [2:0]       funct3_q [DEPTH];
    logic [OFS_W-1:0] ofs_q    [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic [XLEN-1:0]  data_q   [DEPTH];
`ifdef WB_TRACE_EN
    logic [31:0]      inst_q   [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      nxt_pc_q [DEPTH];
    logic [31:0]      inst_out_q, pc_out_q, nxt_pc_out_q;
    logic [31:0]      inst_out_d, pc_out_d, nxt_pc_out_d;
`endif

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, ld_ptr_q, ld_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [4:0]       rd_waddr_q, rd_waddr_d;
    logic             rd_wen_q, rd_wen_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;

    logic             enq, ret, pending, fill_hit, fill_new, unmatched, new_filled, found;
    logic [PTR_W-1:0] nxt_ld, idx;
    logic [XLEN-1:0]  fill_data, new_data;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0]  raw,
                                                 input logic [2:0]       f3,
                                                 input logic [OFS_W-1:0] ofs);
        logic [OFS_W-1:0] h_ofs, w_ofs;
        logic [XLEN-1:0]  b_sh, h_sh, w_sh, res;
        h_ofs = ofs & ~OFS_W'(1);
        w_ofs = ofs & ~OFS_W'(3);
        b_sh  = raw >> {ofs, 3'b000};
        h_sh  = raw >> {h_ofs, 3'b000};
        w_sh  = raw >> {w_ofs, 3'b000};
        res   = raw;
        case (f3)
            3'b000: begin res = {XLEN{b_sh[7]}};  res[7:0]  = b_sh[7:0];  end
            3'b100: begin res = '0;               res[7:0]  = b_sh[7:0];  end
            3'b001: begin res = {XLEN{h_sh[15]}}; res[15:0] = h_sh[15:0]; end
            3'b101: begin res = '0;               res[15:0] = h_sh[15:0]; end
            3'b010: begin
                if (XLEN == 64) begin
                    res = {XLEN{w_sh[31]}};
                    res[31:0] = w_sh[31:0];
                end
            end
            3'b110: begin
                if (XLEN == 64) begin
                    res = '0;
                    res[31:0] = w_sh[31:0];
                end
            end
            default: res = raw;
        endcase
        return res;
    endfunction

    assign o_rdy      = !i_rst && (count_q < CNT_W'(DEPTH));
    assign o_res      = res_q;
    assign o_rd_waddr = rd_waddr_q;
    assign o_rd_wen   = rd_wen_q;
    assign o_vld      = vld_q;
    assign o_count    = count_q;
    assign o_err      = err_q;
`ifdef WB_TRACE_EN
    assign o_inst     = inst_out_q;
    assign o_pc       = pc_out_q;
    assign o_nxt_pc   = nxt_pc_out_q;
`endif

    always_comb begin
        enq        = i_vld && o_rdy;
        ret        = (count_q != '0) && filled_q[head_q];
        // ld_ptr only names a real load while that entry is still unfilled.
        pending    = ld_q[ld_ptr_q] && !filled_q[ld_ptr_q];
        fill_hit   = i_dmem_rvld && pending;
        fill_new   = i_dmem_rvld && !pending && enq && i_mem_reg;
        unmatched  = i_dmem_rvld && !pending && !(enq && i_mem_reg);
        fill_data  = extract(i_dmem_rdata, funct3_q[ld_ptr_q], ofs_q[ld_ptr_q]);
        new_data   = i_mem_reg ? extract(i_dmem_rdata, i_funct3, i_res[OFS_W-1:0]) : i_res;
        new_filled = !i_mem_reg || fill_new;

        // Next pending load is the first unfilled load found walking forward from ld_ptr.
        nxt_ld = tail_q;
        found  = 1'b0;
        idx    = ld_ptr_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            idx = ld_ptr_q + PTR_W'(i);
            if (!found && ld_q[idx] && !filled_q[idx]) begin
                nxt_ld = idx;
                found  = 1'b1;
            end
        end

        ld_ptr_d = ld_ptr_q;
        if (fill_hit) begin
            ld_ptr_d = found ? nxt_ld : tail_q;
        end else if (!pending && enq && i_mem_reg) begin
            ld_ptr_d = tail_q;
        end

        head_d     = head_q + PTR_W'(ret);
        tail_d     = tail_q + PTR_W'(enq);
        count_d    = count_q + CNT_W'(enq) - CNT_W'(ret);
        err_d      = err_q || unmatched;
        vld_d      = ret;
        rd_wen_d   = ret && wen_q[head_q] && (rd_q[head_q] != 5'd0);
        res_d      = res_q;
        rd_waddr_d = rd_waddr_q;
        if (ret) begin
            res_d      = data_q[head_q];
            rd_waddr_d = rd_q[head_q];
        end
`ifdef WB_TRACE_EN
        inst_out_d   = inst_out_q;
        pc_out_d     = pc_out_q;
        nxt_pc_out_d = nxt_pc_out_q;
        if (ret) begin
            inst_out_d   = inst_q[head_q];
            pc_out_d     = pc_q[head_q];
            nxt_pc_out_d = nxt_pc_q[head_q];
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            ld_ptr_q   <= '0;
            count_q    <= '0;
            res_q      <= '0;
            rd_waddr_q <= '0;
            rd_wen_q   <= 1'b0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            ld_q       <= '0;
            filled_q   <= '0;
`ifdef WB_TRACE_EN
            inst_out_q   <= '0;
            pc_out_q     <= '0;
            nxt_pc_out_q <= '0;
`endif
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            ld_ptr_q   <= ld_ptr_d;
            count_q    <= count_d;
            res_q      <= res_d;
            rd_waddr_q <= rd_waddr_d;
            rd_wen_q   <= rd_wen_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            if (enq) begin
                ld_q[tail_q]     <= i_mem_reg;
                filled_q[tail_q] <= new_filled;
            end
            if (fill_hit) begin
                filled_q[ld_ptr_q] <= 1'b1;
            end
`ifdef WB_TRACE_EN
            inst_out_q   <= inst_out_d;
            pc_out_q     <= pc_out_d;
            nxt_pc_out_q <= nxt_pc_out_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) begin
            funct3_q[tail_q] <= i_funct3;
            ofs_q[tail_q]    <= i_res[OFS_W-1:0];
            rd_q[tail_q]     <= i_rd_waddr;
            wen_q[tail_q]    <= i_rd_wen;
            data_q[tail_q]   <= new_data;
`ifdef WB_TRACE_EN
            inst_q[tail_q]   <= i_inst;
            pc_q[tail_q]     <= i_pc;
            nxt_pc_q[tail_q] <= i_nxt_pc;
`endif
        end
        if (fill_hit) begin
            data_q[ld_ptr_q] <= fill_data;
        end
    end

endmodule

// File: tb/tb_wb_retire.sv
// Directed self-checking bench for wb_retire (XLEN=32, DEPTH=4).
module tb_wb_retire;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_vld, o_rdy, i_mem_reg;
    logic [31:0] i_res;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_waddr;
    logic        i_rd_wen, i_dmem_rvld;
    logic [31:0] i_dmem_rdata, o_res;
    logic [4:0]  o_rd_waddr;
    logic        o_rd_wen, o_vld, o_err;
    logic [2:0]  o_count;
`ifdef WB_TRACE_EN
    logic [31:0] i_inst, i_pc, i_nxt_pc, o_inst, o_pc, o_nxt_pc;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_retire #(.XLEN(32), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_mem_reg(i_mem_reg),
        .i_res(i_res), .i_funct3(i_funct3), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
        .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata), .o_res(o_res),
        .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen), .o_vld(o_vld), .o_count(o_count),
`ifdef WB_TRACE_EN
        .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
        .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
`endif
        .o_err(o_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i_vld = 1'b0; i_mem_reg = 1'b0; i_res = '0; i_funct3 = '0;
        i_rd_waddr = '0; i_rd_wen = 1'b0; i_dmem_rvld = 1'b0; i_dmem_rdata = '0;
`ifdef WB_TRACE_EN
        i_inst = '0; i_pc = '0; i_nxt_pc = '0;
`endif
    endtask

    task automatic push(input logic ld, input logic [31:0] res, input logic [2:0] f3,
                        input logic [4:0] rd);
        i_vld = 1'b1; i_mem_reg = ld; i_res = res; i_funct3 = f3;
        i_rd_waddr = rd; i_rd_wen = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        i_rst = 1'b1;
        step(); step();
        checks++;
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy got=%b exp=0", o_rdy); end
        checks++;
        if ({o_vld, o_rd_wen, o_err, o_count} !== 6'd0) begin
            failures++;
            $display("FAIL rst_flags got=%b%b%b cnt=%0d exp=000 cnt=0", o_vld, o_rd_wen, o_err, o_count);
        end
        checks++;
        if (o_res !== 32'd0 || o_rd_waddr !== 5'd0) begin
            failures++; $display("FAIL rst_data got res=%h rd=%0d exp 0/0", o_res, o_rd_waddr);
        end
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL rdy_after_rst got=%b exp=1", o_rdy); end
    endtask

    task automatic test_alu;
        push(1'b0, 32'h1234, 3'b000, 5'd5);
        step();
        idle();
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL alu_early got=%b exp=0", o_vld); end
        step();
        checks++;
        if (o_vld !== 1'b1 || o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd5 || o_res !== 32'h1234) begin
            failures++;
            $display("FAIL alu_retire got vld=%b wen=%b rd=%0d res=%h exp 1/1/5/00001234",
                     o_vld, o_rd_wen, o_rd_waddr, o_res);
        end
        checks++;
        if (o_count !== 3'd0) begin failures++; $display("FAIL alu_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_loads;
        // LB at offset 3
        push(1'b1, 32'h0000_0003, 3'b000, 5'd6);
        step();
        idle();
        i_dmem_rvld = 1'b1; i_dmem_rdata = 32'h80FF_0000;
        step();
        idle();
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL lb_early got=%b exp=0", o_vld); end
        step();
        checks++;
        if (o_vld !== 1'b1 || o_res !== 32'hFFFF_FF80 || o_rd_waddr !== 5'd6) begin
            failures++;
            $display("FAIL lb_data got vld=%b res=%h rd=%0d exp 1/ffffff80/6", o_vld, o_res, o_rd_waddr);
        end
        // LHU at offset 2, response after a gap
        push(1'b1, 32'h0000_1002, 3'b101, 5'd9);
        step();
        idle();
        step();
        i_dmem_rvld = 1'b1; i_dmem_rdata = 32'h8001_0000;
        step();
        idle();
        step();
        checks++;
        if (o_vld !== 1'b1 || o_res !== 32'h0000_8001 || o_rd_waddr !== 5'd9) begin
            failures++;
            $display("FAIL lhu_data got vld=%b res=%h rd=%0d exp 1/00008001/9", o_vld, o_res, o_rd_waddr);
        end
        // LH with its response in the enqueue cycle
        push(1'b1, 32'h0000_0002, 3'b001, 5'd10);
        i_dmem_rvld = 1'b1; i_dmem_rdata = 32'h8001_0000;
        step();
        idle();
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL lh_same_early got=%b exp=0", o_vld); end
        step();
        checks++;
        if (o_vld !== 1'b1 || o_res !== 32'hFFFF_8001 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL lh_same got vld=%b res=%h err=%b exp 1/ffff8001/0", o_vld, o_res, o_err);
        end
    endtask

    task automatic test_order;
        push(1'b1, 32'h0, 3'b010, 5'd7);
        step();
        push(1'b0, 32'hAA, 3'b000, 5'd8);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o_vld !== 1'b0) begin failures++; $display("FAIL order_wait%0d got=%b exp=0", i, o_vld); end
        end
        i_dmem_rvld = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
        step();
        idle();
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL order_resp got=%b exp=0", o_vld); end
        step();
        checks++;
        if (o_vld !== 1'b1 || o_rd_waddr !== 5'd7 || o_res !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL order_ld got vld=%b rd=%0d res=%h exp 1/7/deadbeef", o_vld, o_rd_waddr, o_res);
        end
        step();
        checks++;
        if (o_vld !== 1'b1 || o_rd_waddr !== 5'd8 || o_res !== 32'hAA) begin
            failures++;
            $display("FAIL order_alu got vld=%b rd=%0d res=%h exp 1/8/000000aa", o_vld, o_rd_waddr, o_res);
        end
    endtask

    task automatic test_full;
        for (int k = 1; k <= 4; k++) begin
            push(1'b1, 32'h0, 3'b100, 5'(k));
            step();
        end
        push(1'b0, 32'h55, 3'b000, 5'd20);
        checks++;
        if (o_rdy !== 1'b0 || o_count !== 3'd4) begin
            failures++; $display("FAIL full got rdy=%b cnt=%0d exp 0/4", o_rdy, o_count);
        end
        step();
        idle();
        checks++;
        if (o_count !== 3'd4) begin failures++; $display("FAIL full_hold got=%0d exp=4", o_count); end
        for (int k = 1; k <= 4; k++) begin
            i_dmem_rvld = 1'b1; i_dmem_rdata = 32'h11 * k;
            step();
            if (k > 1) begin
                checks++;
                if (o_vld !== 1'b1 || o_rd_waddr !== 5'(k - 1) || o_res !== 32'(32'h11 * (k - 1))) begin
                    failures++;
                    $display("FAIL full_ret%0d got vld=%b rd=%0d res=%h exp 1/%0d/%h",
                             k - 1, o_vld, o_rd_waddr, o_res, k - 1, 32'h11 * (k - 1));
                end
            end
        end
        idle();
        step();
        checks++;
        if (o_vld !== 1'b1 || o_rd_waddr !== 5'd4 || o_res !== 32'h44) begin
            failures++;
            $display("FAIL full_ret4 got vld=%b rd=%0d res=%h exp 1/4/00000044", o_vld, o_rd_waddr, o_res);
        end
        step();
        checks++;
        if (o_vld !== 1'b0 || o_count !== 3'd0) begin
            failures++; $display("FAIL full_drain got vld=%b cnt=%0d exp 0/0", o_vld, o_count);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 32'h100 + i, 3'b000, 5'(i + 1));
            step();
            if (i > 0) begin
                checks++;
                if (o_vld !== 1'b1 || o_res !== 32'(32'h100 + i - 1)) begin
                    failures++;
                    $display("FAIL b2b%0d got vld=%b res=%h exp 1/%h", i, o_vld, o_res, 32'h100 + i - 1);
                end
            end
        end
        idle();
        step();
        checks++;
        if (o_vld !== 1'b1 || o_res !== 32'h105 || o_count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_last got vld=%b res=%h cnt=%0d exp 1/00000105/0", o_vld, o_res, o_count);
        end
    endtask

    task automatic test_err_rd0_reset;
        i_dmem_rvld = 1'b1; i_dmem_rdata = 32'h1;
        step();
        idle();
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", o_err); end
        step(); step();
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", o_err); end
        push(1'b0, 32'h77, 3'b000, 5'd0);
        step();
        idle();
        step();
        checks++;
        if (o_vld !== 1'b1 || o_rd_wen !== 1'b0) begin
            failures++; $display("FAIL rd0 got vld=%b wen=%b exp 1/0", o_vld, o_rd_wen);
        end
        for (int k = 1; k <= 3; k++) begin
            push(1'b1, 32'h0, 3'b010, 5'(k));
            step();
        end
        idle();
        checks++;
        if (o_count !== 3'd3) begin failures++; $display("FAIL pre_rst_cnt got=%0d exp=3", o_count); end
        i_rst = 1'b1;
        step();
        checks++;
        if (o_count !== 3'd0 || o_vld !== 1'b0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got cnt=%0d vld=%b err=%b exp 0/0/0", o_count, o_vld, o_err);
        end
        i_rst = 1'b0;
        step();
        checks++;
        if (o_vld !== 1'b0 || o_count !== 3'd0) begin
            failures++; $display("FAIL post_rst got vld=%b cnt=%0d exp 0/0", o_vld, o_count);
        end
        push(1'b0, 32'h99, 3'b000, 5'd4);
        step();
        idle();
        step();
        checks++;
        if (o_vld !== 1'b1 || o_res !== 32'h99 || o_rd_waddr !== 5'd4) begin
            failures++;
            $display("FAIL post_rst_alu got vld=%b res=%h rd=%0d exp 1/00000099/4", o_vld, o_res, o_rd_waddr);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu();
        test_loads();
        test_order();
        test_full();
        test_back_to_back();
        test_err_rd0_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
